// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared multi-cycle ALU.
// It accepts one request at a time, launches it, waits for the result or a timeout, and holds the response until the consumer accepts it.
module alu_arbiter #(
   parameter int unsigned DW  = 32,
   parameter int unsigned TMO = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [DW-1:0] req0_op1,
   input  logic [DW-1:0] req0_op2,
   input  logic [4:0]    req0_aluop,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [DW-1:0] req1_op1,
   input  logic [DW-1:0] req1_op2,
   input  logic [4:0]    req1_aluop,
   output logic [DW-1:0] alu_op1,
   output logic [DW-1:0] alu_op2,
   output logic [4:0]    alu_aluop,
   output logic          alu_start,
   input  logic          alu_done,
   input  logic [DW-1:0] alu_result,
   output logic          rsp0_valid,
   input  logic          rsp0_ready,
   output logic          rsp1_valid,
   input  logic          rsp1_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic          busy,
   output logic          grant_id
);

   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_last_grant;
   logic            r_grant_id;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   r_op1;
   logic [DW-1:0]   r_op2;
   logic [4:0]      r_aluop;
   logic [DW-1:0]   r_rsp_data;
   logic            r_rsp_err;
   logic            w_sel;
   logic            w_accept;
   logic            w_timeout;
   logic            w_rsp_ready;

   // Round-robin pick: a lone requester wins; on contention the port not granted last time wins.
   assign w_sel       = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
   assign w_accept    = req0_ready | req1_ready;
   assign w_timeout   = (r_cnt == CW'(TMO - 1)) & ~alu_done;
   assign w_rsp_ready = r_grant_id ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            req0_ready = req0_valid & ~w_sel;
            req1_ready = req1_valid & w_sel;
            if (req0_valid | req1_valid) w_next = S_ISSUE;
         end
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (alu_done | w_timeout) w_next = S_RESP;
         S_RESP:  if (w_rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Request capture, timeout counting and response registration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant <= 1'b1;
         r_grant_id   <= 1'b0;
         r_cnt        <= '0;
         r_op1        <= '0;
         r_op2        <= '0;
         r_aluop      <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op1        <= w_sel ? req1_op1 : req0_op1;
            r_op2        <= w_sel ? req1_op2 : req0_op2;
            r_aluop      <= w_sel ? req1_aluop : req0_aluop;
            r_grant_id   <= w_sel;
            r_last_grant <= w_sel;
         end
         if (r_state == S_ISSUE) r_cnt <= '0;
         if (r_state == S_WAIT) begin
            if (alu_done) begin
               r_rsp_data <= alu_result;
               r_rsp_err  <= 1'b0;
            end else if (w_timeout) begin
               r_rsp_data <= '0;
               r_rsp_err  <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign alu_op1    = r_op1;
   assign alu_op2    = r_op2;
   assign alu_aluop  = r_aluop;
   assign alu_start  = (r_state == S_ISSUE);
   assign busy       = (r_state != S_IDLE);
   assign grant_id   = r_grant_id;
   assign rsp0_valid = (r_state == S_RESP) & ~r_grant_id;
   assign rsp1_valid = (r_state == S_RESP) & r_grant_id;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;

endmodule
